div_request_ctrl: RTL and testbench



---
 rtl/div_request_ctrl.sv | 121 ++++++++++++
 tb/tb_div_request_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_request_ctrl.sv
// Divide request controller: maps RISC-V DIV/DIVU/REM/REMU onto an iterative unsigned divider.
// Optional macro DIV_FASTPATH_EN answers |rs1| < |rs2| locally instead of issuing to the divider.
module div_request_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [1:0]      op_sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            div_data_valid,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    input  logic            div_data_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_busy, r_result_valid, r_div_valid;
    logic            r_rem, r_negq, r_negr;
    logic [XLEN-1:0] r_result, r_pend, r_dividend, r_divisor;

    logic            w_accept, w_signed, w_rem, w_neg1, w_neg2;
    logic            w_div0, w_ovf, w_fast, w_special;
    logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res, w_raw, w_fixed;

    // op_sel[0]=0 selects the signed variants, op_sel[1]=1 selects remainder
    assign w_accept = (r_state == S_IDLE) && op_valid;
    assign w_signed = !op_sel[0];
    assign w_rem    = op_sel[1];
    assign w_neg1   = w_signed && rs1[XLEN-1];
    assign w_neg2   = w_signed && rs2[XLEN-1];
    assign w_mag1   = w_neg1 ? -rs1 : rs1;
    assign w_mag2   = w_neg2 ? -rs2 : rs2;
    assign w_div0   = (rs2 == '0);
    assign w_ovf    = w_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

`ifdef DIV_FASTPATH_EN
    assign w_fast   = !w_div0 && (w_mag1 < w_mag2);
`else
    assign w_fast   = 1'b0;
`endif

    assign w_special = w_div0 || w_ovf || w_fast;

    always_comb begin
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = w_rem ? rs1 : '1;
        else if (w_ovf)
            w_spec_res = w_rem ? '0 : rs1;
        else
            w_spec_res = w_rem ? rs1 : '0;
    end

    // Negating zero yields zero, so zero results need no special handling
    assign w_raw   = r_rem ? div_remainder : div_quotient;
    assign w_fixed = (r_rem ? r_negr : r_negq) ? -w_raw : w_raw;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (op_valid) w_next = w_special ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (div_data_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_div_valid    <= 1'b0;
            r_rem          <= 1'b0;
            r_negq         <= 1'b0;
            r_negr         <= 1'b0;
            r_result       <= '0;
            r_pend         <= '0;
            r_dividend     <= '0;
            r_divisor      <= '0;
        end else begin
            r_busy         <= (w_next != S_IDLE);
            r_div_valid    <= (w_next == S_ISSUE);
            r_result_valid <= (r_state == S_DONE);
            if (w_accept) begin
                r_rem      <= w_rem;
                r_negq     <= w_neg1 ^ w_neg2;
                r_negr     <= w_neg1;
                r_dividend <= w_mag1;
                r_divisor  <= w_mag2;
                if (w_special) r_pend <= w_spec_res;
            end
            if (r_state == S_WAIT && div_data_ready)
                r_pend <= w_fixed;
            if (r_state == S_DONE)
                r_result <= r_pend;
        end
    end

    assign busy           = r_busy;
    assign result_valid   = r_result_valid;
    assign result         = r_result;
    assign div_data_valid = r_div_valid;
    assign div_dividend   = r_dividend;
    assign div_divisor    = r_divisor;

endmodule

// File: tb/tb_div_request_ctrl.sv
// Directed bench for div_request_ctrl with an inline divider stub and result scoreboard.
module tb_div_request_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] rs1, rs2;
    logic        busy, result_valid, div_data_valid, div_data_ready;
    logic [31:0] result, div_dividend, div_divisor, div_quotient, div_remainder;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] sb_q[$];
    logic        fast_en;

    div_request_ctrl #(.XLEN(32)) dut (
        .CLK(CLK), .rst_n(rst_n), .op_valid(op_valid), .op_sel(op_sel),
        .rs1(rs1), .rs2(rs2), .busy(busy), .result_valid(result_valid),
        .result(result), .div_data_valid(div_data_valid),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_data_ready(div_data_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Architectural RISC-V M-extension result
    function automatic logic [31:0] ref_model(input logic [1:0] sel, input logic [31:0] a,
                                              input logic [31:0] b);
        if (b == 32'd0) return sel[1] ? a : 32'hFFFF_FFFF;
        if (!sel[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return sel[1] ? 32'd0 : 32'h8000_0000;
            return sel[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return sel[1] ? a % b : a / b;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ":busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ":result_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, ":result"}, result, 32'd0);
        chk({tag, ":div_data_valid"}, {31'd0, div_data_valid}, 32'd0);
        chk({tag, ":div_dividend"}, div_dividend, 32'd0);
        chk({tag, ":div_divisor"}, div_divisor, 32'd0);
    endtask

    // Drive one op, act as the divider, and compare the result against the scoreboard.
    task automatic do_op(input string tag, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_issue, input logic inject);
        int          n, issues, rdy_at, rdy_n;
        logic        done;
        logic [31:0] m1, m2;
        m1 = (!sel[0] && a[31]) ? -a : a;
        m2 = (!sel[0] && b[31]) ? -b : b;
        issues = 0; rdy_at = -1; rdy_n = -100; done = 1'b0;
        @(negedge CLK);
        op_valid = 1'b1; op_sel = sel; rs1 = a; rs2 = b;
        sb_q.push_back(ref_model(sel, a, b));
        @(negedge CLK);
        op_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
        chk({tag, ":busy_after_accept"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!done && n < 64) begin
            if (div_data_valid) begin
                issues++;
                chk({tag, ":dividend"}, div_dividend, m1);
                chk({tag, ":divisor"}, div_divisor, m2);
                rdy_at = n + 3;
            end
            if (result_valid) begin
                chk({tag, ":busy_at_result"}, {31'd0, busy}, 32'd0);
                chk({tag, ":result"}, result, (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF);
                if (exp_issue) chk({tag, ":latency_after_ready"}, 32'(n), 32'(rdy_n + 2));
                else           chk({tag, ":latency_special"}, 32'(n), 32'd2);
                done = 1'b1;
            end
            div_data_ready = (n == rdy_at);
            if (div_data_ready) begin
                chk({tag, ":operands_held"}, div_dividend ^ div_divisor, m1 ^ m2);
                div_quotient  = (m2 != 0) ? m1 / m2 : 32'hFFFF_FFFF;
                div_remainder = (m2 != 0) ? m1 % m2 : m1;
                rdy_n = n;
            end
            op_valid = inject && (n == rdy_at - 2);
            if (op_valid) begin
                op_sel = 2'b01; rs1 = 32'd99; rs2 = 32'd1;
            end
            if (!done) begin
                @(negedge CLK);
                n++;
            end
        end
        div_data_ready = 1'b0; op_valid = 1'b0;
        chk({tag, ":completed"}, {31'd0, done}, 32'd1);
        if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
        chk({tag, ":issue_count"}, 32'(issues), {31'd0, exp_issue});
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk({tag, ":no_stray_result"}, {31'd0, result_valid}, 32'd0);
            chk({tag, ":no_stray_issue"}, {31'd0, div_data_valid}, 32'd0);
        end
    endtask

    initial begin
`ifdef DIV_FASTPATH_EN
        fast_en = 1'b1;
`else
        fast_en = 1'b0;
`endif
        rst_n = 1'b0; op_valid = 1'b0; op_sel = 2'b00; rs1 = '0; rs2 = '0;
        div_data_ready = 1'b0; div_quotient = '0; div_remainder = '0;
        repeat (2) @(negedge CLK);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        do_op("divu_100_7",  2'b01, 32'd100,        32'd7,          1'b1, 1'b0);
        do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0);
        do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0);
        do_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
        do_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
        do_op("divu_by0",    2'b01, 32'd5,          32'd0,          1'b0, 1'b0);
        do_op("rem_by0",     2'b10, 32'hFFFF_FFFB,  32'd0,          1'b0, 1'b0);
        do_op("div_neg_neg", 2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 1'b0);
        do_op("remu_big",    2'b11, 32'hF000_0001,  32'd16,         1'b1, 1'b0);
        do_op("div_inject",  2'b00, 32'd1234,       32'hFFFF_FFFB,  1'b1, 1'b1);

        // Spurious completion while idle must not produce a result
        @(negedge CLK);
        div_data_ready = 1'b1; div_quotient = 32'h1111_1111; div_remainder = 32'h2222_2222;
        @(negedge CLK);
        div_data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("spurious_ready:no_result", {31'd0, result_valid}, 32'd0);
            chk("spurious_ready:busy", {31'd0, busy}, 32'd0);
            @(negedge CLK);
        end

        // Reset while waiting on the divider
        op_valid = 1'b1; op_sel = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge CLK);
        op_valid = 1'b0;
        @(negedge CLK);
        chk("mid_reset:busy_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        @(negedge CLK);
        rst_n = 1'b1;
        do_op("after_reset", 2'b00, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0);

        do_op("divu_3_10", 2'b01, 32'd3, 32'd10, !fast_en, 1'b0);
        do_op("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10, !fast_en, 1'b0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
